pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- A single instance carries one stage's payload, split into a data field and a control field, under a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered ready.
- Adds what the old registers lack: flush (bubble insertion with control bits zeroed), occupancy reporting and a saturating stall counter.

Parameters:
- DATA_W, 128: width of the data payload (PC+4, instruction, operands, immediate).
- CTRL_W, 16: width of the control payload (RegW, MemW, MemR, Branch, ALU op, ...). Forced to 0 whenever the stage is invalid or flushed.
- CNT_W, 16: width of the stall counter.
- FLUSH_CLR_DATA, 0: 1 = flush also clears the data registers; 0 = data registers hold their value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush (branch/jump redirect).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; equals !skid_valid, taken directly from a register.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  stage holds a payload.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main-register data.
- out_ctrl  out  CTRL_W  main-register control, ANDed with out_valid.
- occupancy  out  2  number of entries held, 0..2.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=EMPTY, all main and skid registers = 0, stall_cnt=0.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Handshake events:
  - acc = in_valid & in_ready.
  - fire = out_valid & out_ready.
  - Input latency is 1 cycle: a payload accepted at edge N is visible on out_* after edge N.
- State machine (occupancy = 0/1/2):
  - EMPTY: acc -> ONE, main<=in. Otherwise stay.
  - ONE, acc & fire: stay ONE, main<=in.
  - ONE, acc & !fire: -> TWO, skid<=in, main holds.
  - ONE, !acc & fire: -> EMPTY.
  - ONE, !acc & !fire: hold.
  - TWO: in_ready=0, so acc is impossible. fire -> ONE, main<=skid. !fire -> hold.
- Ordering: strict FIFO order. The skid entry is never emitted before the main entry.
- Throughput: 1 payload per cycle when out_ready is held at 1.
- Flush:
  - Highest priority over acc and fire, applied at the clock edge.
  - Next state=EMPTY. A same-cycle input is discarded, even if in_valid=1 and in_ready=1.
  - Main and skid control registers <= 0.
  - Data registers <= 0 if FLUSH_CLR_DATA=1, otherwise they hold.
  - A same-cycle fire still counts as delivered downstream: the flush only affects the next state.
- Control gating: out_ctrl = out_valid ? ctrl_main : 0. A bubble therefore never presents RegW or MemW.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over the increment: the next value is 0.
  - Flush does not affect stall_cnt.
- Reset asserted mid-operation: immediate return to the reset values above, regardless of state or in-flight handshakes.
- No combinational path from in_valid or out_ready to in_ready.
  - out_valid, out_data and occupancy come from registers only.
  - out_ctrl passes through a single AND gate.

Decomposition:
- Shared package pipe_pkg:
  - State encoding localparams ST_EMPTY=2'b00, ST_ONE=2'b01, ST_TWO=2'b11.
  - Default width constants for the ID/EX instantiation: DATA_W=128, CTRL_W=16.
- One sub-module: pipe_sat_counter, with parameter W and ports clk, rst, inc, clr, q. It provides the saturating stall counter.

Test Plan:
- Reset, then in_valid=1 with in_data=0x...01 and in_ctrl=0x0003, out_ready=1: out_valid=1 and out_ctrl=0x0003 after 1 edge. After 10 back-to-back inputs, 10 outputs in order, occupancy stays 1, in_ready stays 1.
- Backpressure: out_ready=0 and 3 payloads A,B,C offered:
  - A goes to main, B goes to skid, occupancy=2, in_ready=0, C held upstream.
  - Raise out_ready: the order out is A, B, C.
  - stall_cnt equals the number of stalled cycles exactly.
- Flush in TWO with in_valid=1: next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. The flushed input never appears on the output.
  - With FLUSH_CLR_DATA=0, out_data keeps its old value.
  - With FLUSH_CLR_DATA=1, out_data=0.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15. Then cnt_clr=1 for one cycle -> 0, then it increments again.
- Asynchronous reset asserted between edges while in TWO: outputs go to reset values without waiting for a clock edge. After release, normal acceptance resumes.
- Random valid/ready/flush for 10k cycles against a scoreboard: no loss, no duplication, order preserved, out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for pipeline stage registers
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_CTRL_W = 16;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with synchronous clear
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else if (clr) q <= '0;
        else if (inc && !(&q)) q <= q + W'(1);
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, flush and stall counter
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int CTRL_W         = DEF_CTRL_W,
    parameter int CNT_W          = 16,
    parameter bit FLUSH_CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);
    state_t state, state_n;
    logic [DATA_W-1:0] main_d, main_d_n, skid_d, skid_d_n;
    logic [CTRL_W-1:0] main_c, main_c_n, skid_c, skid_c_n;
    logic acc, fire;
    // state bit 1 is the skid-valid flag, bit 0 the main-valid flag
    assign in_ready  = ~state[1];
    assign out_valid = state[0];
    assign occupancy = {state[1], state[0] & ~state[1]};
    assign out_data  = main_d;
    assign out_ctrl  = main_c & {CTRL_W{out_valid}};
    assign acc       = in_valid & in_ready;
    assign fire      = out_valid & out_ready;
    always_comb begin
        state_n  = state;
        main_d_n = main_d;
        main_c_n = main_c;
        skid_d_n = skid_d;
        skid_c_n = skid_c;
        if (flush) begin
            state_n  = ST_EMPTY;
            main_c_n = '0;
            skid_c_n = '0;
            if (FLUSH_CLR_DATA) begin
                main_d_n = '0;
                skid_d_n = '0;
            end
        end else begin
            case (state)
                ST_EMPTY: if (acc) begin
                    state_n  = ST_ONE;
                    main_d_n = in_data;
                    main_c_n = in_ctrl;
                end
                ST_ONE: if (acc && fire) begin
                    main_d_n = in_data;
                    main_c_n = in_ctrl;
                end else if (acc) begin
                    state_n  = ST_TWO;
                    skid_d_n = in_data;
                    skid_c_n = in_ctrl;
                end else if (fire) begin
                    state_n = ST_EMPTY;
                end
                ST_TWO: if (fire) begin
                    state_n  = ST_ONE;
                    main_d_n = skid_d;
                    main_c_n = skid_c;
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_d <= '0;
            main_c <= '0;
            skid_d <= '0;
            skid_c <= '0;
        end else begin
            state  <= state_n;
            main_d <= main_d_n;
            main_c <= main_c_n;
            skid_d <= skid_d_n;
            skid_c <= skid_c_n;
        end
    end
    pipe_sat_counter #(.W(CNT_W)) u_stall (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~out_ready),
        .clr (cnt_clr),
        .q   (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench with directed cases and randomized valid/ready/flush traffic
module tb_pipe_stage_skid;
    localparam int DW = 64;
    localparam int CW = 16;
    localparam int NW = 4;
    localparam int SAT = (1 << NW) - 1;
    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic in_ready, out_valid, in_ready1, out_valid1;
    logic [DW-1:0] out_data, out_data1;
    logic [CW-1:0] out_ctrl, out_ctrl1;
    logic [1:0] occupancy, occupancy1;
    logic [NW-1:0] stall_cnt, stall_cnt1;
    item_t exp_q[$];
    item_t pend_item;
    logic pend = 1'b0;
    int checks = 0, failures = 0, n_out = 0, stall_m = 0, n0 = 0;
    always #5 clk = ~clk;
    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW), .FLUSH_CLR_DATA(1'b0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );
    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW), .FLUSH_CLR_DATA(1'b1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occupancy1),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt1)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic r, input logic f, input logic cl);
        @(posedge clk);
        #1;
        if (pend) exp_q.push_back(pend_item);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
        cnt_clr   = cl;
        pend      = v & in_ready & ~f;
        pend_item = {d, c};
    endtask
    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic do_reset;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        rst       = 1'b1;
        #3;
        exp_q.delete();
        pend    = 1'b0;
        stall_m = 0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            chk("occupancy", occupancy, exp_q.size());
            chk("in_ready", in_ready, exp_q.size() < 2);
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("stall_cnt", stall_cnt, stall_m);
            if (!out_valid) chk("ctrl_gate", out_ctrl, 0);
            if (!out_valid1) chk("ctrl_gate_clr", out_ctrl1, 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_ctrl", out_ctrl, exp_q[0].c);
            end
            stall_m = cnt_clr ? 0 : (exp_q.size() != 0 && !out_ready && stall_m < SAT) ? stall_m + 1 : stall_m;
            if (exp_q.size() != 0 && out_ready) begin
                void'(exp_q.pop_front());
                n_out++;
            end
            if (flush) exp_q.delete();
        end
    end
    initial begin
        do_reset;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_data", out_data, 0);
        chk("rst_stall", stall_cnt, 0);
        drive(1'b1, 64'h1, 16'h0003, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("first_valid", out_valid, 1);
        chk("first_ctrl", out_ctrl, 16'h0003);
        chk("first_data", out_data, 64'h1);
        idle(2);
        n0 = n_out;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h100 + 64'(i), 16'(i + 1), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_occ", occupancy, 1);
                chk("b2b_ready", in_ready, 1);
            end
        end
        idle(3);
        chk("b2b_count", n_out - n0, 10);
        do_reset;
        drive(1'b1, 64'hA, 16'h00A1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hB, 16'h00B2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hC, 16'h00C3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_occ", occupancy, 2);
        chk("bp_ready", in_ready, 0);
        chk("bp_main", out_data, 64'hA);
        chk("bp_stall1", stall_cnt, 1);
        drive(1'b1, 64'hC, 16'h00C3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_out_a", out_data, 64'hA);
        chk("bp_stall2", stall_cnt, 2);
        drive(1'b1, 64'hC, 16'h00C3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_out_b", out_data, 64'hB);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_out_c", out_data, 64'hC);
        chk("bp_out_c_ctrl", out_ctrl, 16'h00C3);
        chk("bp_stall_final", stall_cnt, 2);
        idle(2);
        do_reset;
        drive(1'b1, 64'hA, 16'h00A1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hB, 16'h00B2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hD, 16'h00D4, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_data_hold", out_data, 64'hA);
        chk("fl_data_clr", out_data1, 0);
        drive(1'b1, 64'hE, 16'h00E5, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hF, 16'h00F6, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl1_valid", out_valid, 0);
        chk("fl1_occ", occupancy, 0);
        idle(3);
        do_reset;
        drive(1'b1, 64'hA, 16'h00A1, 1'b0, 1'b0, 1'b0);
        repeat (20) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat", stall_cnt, SAT);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat_clr", stall_cnt, 0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat_reinc", stall_cnt, 1);
        do_reset;
        drive(1'b1, 64'hA, 16'h00A1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hB, 16'h00B2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ar_pre_occ", occupancy, 2);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_data", out_data, 0);
        chk("ar_ctrl", out_ctrl, 0);
        chk("ar_stall", stall_cnt, 0);
        do_reset;
        drive(1'b1, 64'h5EED, 16'h0077, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("ar_resume_valid", out_valid, 1);
        chk("ar_resume_data", out_data, 64'h5EED);
        idle(2);
        do_reset;
        for (int i = 0; i < 10000; i++)
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 16'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        idle(4);
        @(negedge clk);
        chk("drain_occ", occupancy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
